// File: rtl/data_ram_responder_pkg.sv
// Shared types for the MEM-stage RAM responder: FSM state encoding and latched request.
package data_ram_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_WAIT = 2'd1,
    RAM_RESP = 2'd2
  } ram_state_e;

  typedef struct packed {
    logic [ADDR_W-3:0] word;
    logic [SEL_W-1:0]  we;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  // Any word-index bit above the implemented depth makes the request out of range.
  function automatic logic word_out_of_range(input logic [ADDR_W-3:0] word, input int aw);
    return (word >> aw) != '0;
  endfunction

endpackage

// File: rtl/data_ram_responder_bank.sv
// One byte lane of data storage: synchronous write, registered synchronous read.
// Latency: read data valid the cycle after rd_en; write lands at the same edge.
// Backpressure: none; the owning FSM issues at most one access per request.
module ram_byte_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Output register holds its value between reads; out-of-range reads force zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rdata <= 8'h00;
    else if (rd_clr) rdata <= 8'h00;
    else if (rd_en)  rdata <= mem[addr];
  end

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage RAM responder: byte-lane writes and word reads with configurable wait states.
// Latency: ram_ready pulses 1+WAIT_CYCLES cycles after the accepting edge.
// Backpressure: ram_busy stalls the initiator; requests are ignored outside IDLE.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic [SEL_W-1:0]  ram_write_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_write_data,
  output logic [DATA_W-1:0] ram_read_data,
  output logic              ram_ready,
  output logic              ram_busy,
  output logic              ram_error
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  ram_state_e state;
  logic [3:0] wait_cnt;
  ram_req_t   req_q;

  ram_req_t              cur_req;
  logic                  go_resp;
  logic                  oor;
  logic                  is_rd;
  logic                  rd_en;
  logic                  rd_clr;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^ram_addr[1:0];

  // With zero wait states the accepting edge is also the commit edge, so the
  // live inputs feed the banks in IDLE and the latched copy does afterwards.
  assign cur_req = (state == RAM_IDLE) ? ram_req_t'{word:  ram_addr[ADDR_W-1:2],
                                                    we:    ram_write_en,
                                                    wdata: ram_write_data}
                                       : req_q;

  assign go_resp = ((state == RAM_IDLE) && ram_en && (WAIT_CYCLES == 0)) ||
                   ((state == RAM_WAIT) && (wait_cnt == 4'd1));
  assign oor     = word_out_of_range(cur_req.word, ADDR_WIDTH);
  assign is_rd   = (cur_req.we == '0);
  assign rd_en   = go_resp && is_rd && !oor;
  assign rd_clr  = go_resp && is_rd && oor;
  assign idx     = cur_req.word[ADDR_WIDTH-1:0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ram_byte_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (go_resp && !oor && cur_req.we[i]),
      .rd_en  (rd_en),
      .rd_clr (rd_clr),
      .addr   (idx),
      .wdata  (cur_req.wdata[8*i +: 8]),
      .rdata  (ram_read_data[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RAM_IDLE;
      wait_cnt  <= 4'd0;
      req_q     <= '0;
      ram_error <= 1'b0;
    end else begin
      ram_error <= go_resp && oor;
      case (state)
        RAM_IDLE: begin
          if (ram_en) begin
            req_q <= cur_req;
            if (WAIT_CYCLES == 0) begin
              state <= RAM_RESP;
            end else begin
              state    <= RAM_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        RAM_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= RAM_RESP;
        end
        RAM_RESP: state <= RAM_IDLE;
        default:  state <= RAM_IDLE;
      endcase
    end
  end

  assign ram_busy  = (state != RAM_IDLE);
  assign ram_ready = (state == RAM_RESP);

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench: one responder with no wait states, one with three wait states.
module tb_data_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        rst0, en0, rdy0, busy0, err0;
  logic [3:0]  we0;
  logic [31:0] addr0, wd0, rd0;
  logic        rst3, en3, rdy3, busy3, err3;
  logic [3:0]  we3;
  logic [31:0] addr3, wd3, rd3;

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst0), .ram_en(en0), .ram_write_en(we0), .ram_addr(addr0),
    .ram_write_data(wd0), .ram_read_data(rd0), .ram_ready(rdy0), .ram_busy(busy0),
    .ram_error(err0)
  );

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst3), .ram_en(en3), .ram_write_en(we3), .ram_addr(addr3),
    .ram_write_data(wd3), .ram_read_data(rd3), .ram_ready(rdy3), .ram_busy(busy3),
    .ram_error(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait request: response expected in the cycle right after acceptance.
  task automatic t0_op(input string tag, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] data, input logic chk_rd,
                       input logic [31:0] exp_rd, input logic exp_err);
    en0 = 1'b1; we0 = we; addr0 = addr; wd0 = data;
    @(negedge clk);
    check({tag, " ready"}, {31'd0, rdy0}, 32'd1);
    check({tag, " busy"},  {31'd0, busy0}, 32'd1);
    check({tag, " error"}, {31'd0, err0}, {31'd0, exp_err});
    if (chk_rd) check({tag, " rdata"}, rd0, exp_rd);
    en0 = 1'b0;
    @(negedge clk);
    check({tag, " ready_end"}, {31'd0, rdy0}, 32'd0);
    check({tag, " busy_end"},  {31'd0, busy0}, 32'd0);
  endtask

  // Three-wait request: busy for cycles T+1..T+4, ready only in T+4.
  task automatic t3_op(input string tag, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] data, input logic chk_rd, input logic [31:0] exp_rd);
    en3 = 1'b1; we3 = we; addr3 = addr; wd3 = data;
    @(negedge clk);
    en3 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("%s busy c%0d", tag, c),  {31'd0, busy3}, 32'd1);
      check($sformatf("%s ready c%0d", tag, c), {31'd0, rdy3}, 32'd0);
      @(negedge clk);
    end
    check({tag, " ready c4"}, {31'd0, rdy3}, 32'd1);
    check({tag, " busy c4"},  {31'd0, busy3}, 32'd1);
    check({tag, " error"},    {31'd0, err3}, 32'd0);
    if (chk_rd) check({tag, " rdata"}, rd3, exp_rd);
    @(negedge clk);
    check({tag, " ready c5"}, {31'd0, rdy3}, 32'd0);
    check({tag, " busy c5"},  {31'd0, busy3}, 32'd0);
  endtask

  initial begin
    rst0 = 1'b0; en0 = 1'b1; we0 = 4'hF; addr0 = 32'h10; wd0 = 32'hDEADBEEF;
    rst3 = 1'b0; en3 = 1'b1; we3 = 4'hF; addr3 = 32'h20; wd3 = 32'h01020304;
    repeat (3) @(negedge clk);

    // Reset held with a request pending: nothing happens.
    check("rst0 ready", {31'd0, rdy0}, 32'd0);
    check("rst0 busy",  {31'd0, busy0}, 32'd0);
    check("rst0 rdata", rd0, 32'd0);
    check("rst3 ready", {31'd0, rdy3}, 32'd0);
    check("rst3 busy",  {31'd0, busy3}, 32'd0);
    check("rst3 rdata", rd3, 32'd0);

    // Release with ram_en still high: accepted at the first edge.
    rst0 = 1'b1;
    t0_op("wr10", 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    check("wr10 rdata untouched", rd0, 32'd0);
    t0_op("rd10a", 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);

    t0_op("wr12 lane2", 4'b0100, 32'h12, 32'h00AB0000, 1'b0, 32'h0, 1'b0);
    check("wr12 rdata held", rd0, 32'hDEADBEEF);
    t0_op("rd10b", 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEABBEEF, 1'b0);
    t0_op("wr10 hi", 4'b1100, 32'h10, 32'h12340000, 1'b0, 32'h0, 1'b0);
    t0_op("rd10c", 4'h0, 32'h10, 32'h0, 1'b1, 32'h1234BEEF, 1'b0);

    // Out-of-range write must not alias onto word 0.
    t0_op("wr00", 4'hF, 32'h0, 32'h11111111, 1'b0, 32'h0, 1'b0);
    t0_op("wr oor", 4'hF, 32'h00001000, 32'h00000055, 1'b0, 32'h0, 1'b1);
    t0_op("rd00", 4'h0, 32'h0, 32'h0, 1'b1, 32'h11111111, 1'b0);
    t0_op("rd10d", 4'h0, 32'h10, 32'h0, 1'b1, 32'h1234BEEF, 1'b0);
    t0_op("rd oor", 4'h0, 32'h00001000, 32'h0, 1'b1, 32'h0, 1'b1);
    t0_op("rd oor hi", 4'h0, 32'h80000000, 32'h0, 1'b1, 32'h0, 1'b1);

    // Request held through RESP is served again only after an IDLE cycle.
    en0 = 1'b1; we0 = 4'h0; addr0 = 32'h12;
    @(negedge clk);
    check("b2b ready1", {31'd0, rdy0}, 32'd1);
    check("b2b rdata1", rd0, 32'h1234BEEF);
    @(negedge clk);
    check("b2b idle ready", {31'd0, rdy0}, 32'd0);
    check("b2b idle busy",  {31'd0, busy0}, 32'd0);
    addr0 = 32'h0;
    @(negedge clk);
    check("b2b ready2", {31'd0, rdy0}, 32'd1);
    check("b2b rdata2", rd0, 32'h11111111);
    en0 = 1'b0;
    @(negedge clk);

    // Three wait states.
    en3 = 1'b0;
    rst3 = 1'b1;
    @(negedge clk);
    t3_op("w3 wr20", 4'hF, 32'h20, 32'h01020304, 1'b0, 32'h0);

    // Read with inputs changing during WAIT: latched request wins.
    en3 = 1'b1; we3 = 4'h0; addr3 = 32'h20;
    @(negedge clk);
    check("w3 rd c1 busy",  {31'd0, busy3}, 32'd1);
    we3 = 4'hF; addr3 = 32'h24; wd3 = 32'hFFFFFFFF;
    @(negedge clk);
    check("w3 rd c2 ready", {31'd0, rdy3}, 32'd0);
    @(negedge clk);
    check("w3 rd c3 ready", {31'd0, rdy3}, 32'd0);
    en3 = 1'b0;
    @(negedge clk);
    check("w3 rd c4 ready", {31'd0, rdy3}, 32'd1);
    check("w3 rd rdata",    rd3, 32'h01020304);
    @(negedge clk);
    check("w3 rd c5 busy",  {31'd0, busy3}, 32'd0);

    // Reset in the second WAIT cycle drops the pending write.
    en3 = 1'b1; we3 = 4'hF; addr3 = 32'h20; wd3 = 32'hCAFEF00D;
    @(negedge clk);
    en3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("midrst busy",  {31'd0, busy3}, 32'd0);
    check("midrst ready", {31'd0, rdy3}, 32'd0);
    check("midrst rdata", rd3, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("midrst no ready %0d", c), {31'd0, rdy3}, 32'd0);
    end
    rst3 = 1'b1;
    @(negedge clk);
    check("post rst ready", {31'd0, rdy3}, 32'd0);
    t3_op("w3 rd20 after rst", 4'h0, 32'h20, 32'h0, 1'b1, 32'h01020304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
